// File: rtl/conv3x3_ctrl_pkg.sv
// Shared definitions for conv3x3_ctrl: data-width macros, FSM encodings and window helpers.
// The stride-2 option is selected in the top file with the CONV_STRIDE2_EN macro.
`ifndef IMG_DATA_WIDTH
`define IMG_DATA_WIDTH 8
`endif
`ifndef IMG_DATA_MATRIX_WIDTH
`define IMG_DATA_MATRIX_WIDTH (`IMG_DATA_WIDTH*9)
`endif

package conv3x3_ctrl_pkg;
    localparam int DATA_W = `IMG_DATA_WIDTH;
    localparam int MAT_W  = `IMG_DATA_MATRIX_WIDTH;
    localparam int RES_W  = 2 * DATA_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef logic [DATA_W-1:0] pix_t;
    typedef logic [MAT_W-1:0]  mat_t;
    // Ascending packed indices put window[0][0] (top-left) in the MSB field.
    typedef logic [0:2][0:2][DATA_W-1:0] win_t;

    localparam pix_t NUM_1 = pix_t'(1);
    localparam pix_t NUM_2 = pix_t'(2);

    function automatic win_t win_shift(input win_t w, input pix_t top, input pix_t mid,
                                       input pix_t bot);
        win_t n;
        for (int r = 0; r < 3; r++) begin
            n[r][0] = w[r][1];
            n[r][1] = w[r][2];
        end
        n[0][2] = top;
        n[1][2] = mid;
        n[2][2] = bot;
        return n;
    endfunction
endpackage

// File: rtl/conv3x3_ctrl_line_buf.sv
// conv_line_buf: DEPTH-deep pixel delay line that advances only when en is high.
module conv_line_buf
    import conv3x3_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PIX_W = DATA_W
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv3x3_ctrl.sv
// conv3x3_ctrl: raster-scan 3x3 window sequencer feeding an external filter3x3 core.
// Define CONV_STRIDE2_EN to issue only windows whose top-left row and column are even.
module conv3x3_ctrl
    import conv3x3_ctrl_pkg::*;
#(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int FILTER_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [DATA_W-1:0]        pix_data,
    input  logic                     coef_load,
    input  logic [MAT_W-1:0]         coef_data,
    output logic                     filt_ena,
    output logic [MAT_W-1:0]         filt_matrix,
    output logic [MAT_W-1:0]         filt_coef,
    input  logic [RES_W-1:0]         filt_out,
    output logic                     res_valid,
    output logic [RES_W-1:0]         res_data,
    output logic [$clog2(IMG_H)-1:0] res_row,
    output logic [$clog2(IMG_W)-1:0] res_col
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int DW = (FILTER_LAT > 1) ? $clog2(FILTER_LAT) : 1;

    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_TWO    = RW'(2);
    localparam logic [CW-1:0] COL_TWO    = CW'(2);
    localparam logic [RW-1:0] ROW_ONE    = RW'(1);
    localparam logic [CW-1:0] COL_ONE    = CW'(1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(FILTER_LAT - 1);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    logic [1:0]    state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] drain_cnt;
    logic          accept;
    logic          last_pix;
    logic          win_done;

    assign pix_ready = (state == ST_STREAM);
    assign busy      = (state != ST_IDLE);
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
    assign done      = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

`ifdef CONV_STRIDE2_EN
    assign win_done = (row >= ROW_TWO) && (col >= COL_TWO) && !row[0] && !col[0];
`else
    assign win_done = (row >= ROW_TWO) && (col >= COL_TWO);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
            filt_coef <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (coef_load) begin
                        filt_coef <= coef_data;
                    end
                    if (start) begin
                        state <= ST_STREAM;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (last_pix) begin
                            state     <= ST_DRAIN;
                            row       <= '0;
                            col       <= '0;
                            drain_cnt <= '0;
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + ROW_ONE;
                        end else begin
                            col <= col + COL_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p0: line buffers and the window shift on accepted pixels only.
    pix_t lb0_out;
    pix_t lb1_out;
    win_t win_p0;
    win_t win_nxt;

    conv_line_buf #(.DEPTH(IMG_W), .PIX_W(DATA_W)) u_lb0 (
        .clk  (clk),
        .en   (accept),
        .din  (pix_data),
        .dout (lb0_out)
    );

    conv_line_buf #(.DEPTH(IMG_W), .PIX_W(DATA_W)) u_lb1 (
        .clk  (clk),
        .en   (accept),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    assign win_nxt = win_shift(win_p0, lb1_out, lb0_out, pix_data);

    always_ff @(posedge clk) begin
        if (accept) begin
            win_p0 <= win_nxt;
        end
    end

    // Stage p1: hand a completed window to the filter together with its coordinate tag.
    logic [RW-1:0] row_p1;
    logic [CW-1:0] col_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_ena    <= 1'b0;
            filt_matrix <= '0;
            row_p1      <= '0;
            col_p1      <= '0;
        end else begin
            filt_ena <= accept && win_done;
            if (accept && win_done) begin
                filt_matrix <= win_nxt;
                row_p1      <= row - ROW_TWO;
                col_p1      <= col - COL_TWO;
            end
        end
    end

    // Stage p2: tag pipeline matching the filter latency.
    logic          vld_p2 [FILTER_LAT];
    logic [RW-1:0] row_p2 [FILTER_LAT];
    logic [CW-1:0] col_p2 [FILTER_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FILTER_LAT; i++) begin
                vld_p2[i] <= 1'b0;
                row_p2[i] <= '0;
                col_p2[i] <= '0;
            end
        end else begin
            vld_p2[0] <= filt_ena;
            row_p2[0] <= row_p1;
            col_p2[0] <= col_p1;
            for (int i = 1; i < FILTER_LAT; i++) begin
                vld_p2[i] <= vld_p2[i-1];
                row_p2[i] <= row_p2[i-1];
                col_p2[i] <= col_p2[i-1];
            end
        end
    end

    assign res_valid = vld_p2[FILTER_LAT-1];
    assign res_row   = row_p2[FILTER_LAT-1];
    assign res_col   = col_p2[FILTER_LAT-1];
    assign res_data  = res_valid ? filt_out : '0;
endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Self-checking bench for conv3x3_ctrl on a 4x4 image with a behavioural filter3x3 model.
`timescale 1ns/1ps
module tb_conv3x3_ctrl;
    import conv3x3_ctrl_pkg::*;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int FLAT = 2;
`ifdef CONV_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
    localparam int NWIN    = 1;
`else
    localparam bit STRIDE2 = 1'b0;
    localparam int NWIN    = 4;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             pix_valid;
    logic             pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic             coef_load;
    logic [MAT_W-1:0] coef_data;
    logic             filt_ena;
    logic [MAT_W-1:0] filt_matrix;
    logic [MAT_W-1:0] filt_coef;
    logic [RES_W-1:0] filt_out;
    logic             res_valid;
    logic [RES_W-1:0] res_data;
    logic [1:0]       res_row;
    logic [1:0]       res_col;

    conv3x3_ctrl #(.IMG_W(W), .IMG_H(H), .FILTER_LAT(FLAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .coef_load   (coef_load),
        .coef_data   (coef_data),
        .filt_ena    (filt_ena),
        .filt_matrix (filt_matrix),
        .filt_coef   (filt_coef),
        .filt_out    (filt_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_row     (res_row),
        .res_col     (res_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External filter3x3 model: multiply-accumulate, FLAT register stages.
    logic [RES_W-1:0] fpipe [FLAT];

    function automatic logic [RES_W-1:0] fsum(input logic [MAT_W-1:0] m, input logic [MAT_W-1:0] c);
        logic [RES_W-1:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            s = s + RES_W'(m[i*DATA_W +: DATA_W] * c[i*DATA_W +: DATA_W]);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (filt_ena) fpipe[0] <= fsum(filt_matrix, filt_coef);
        for (int i = 1; i < FLAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign filt_out = fpipe[FLAT-1];

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
    } res_t;

    typedef struct packed {
        logic [DATA_W-1:0] coef;
        logic              gap;
        logic              mid_coef;
        logic              mid_start;
        logic [3:0][15:0]  res;
    } vec_t;

    res_t sbq[$];
    vec_t vecs[5];
    int   n_cmp;
    int   n_bad;
    int   n_res;
    int   n_done;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [DATA_W-1:0] coef, input logic gap, input logic mc,
                                input logic ms, input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.coef      = coef;
        v.gap       = gap;
        v.mid_coef  = mc;
        v.mid_start = ms;
        v.res[0]    = 16'(e0);
        v.res[1]    = 16'(e1);
        v.res[2]    = 16'(e2);
        v.res[3]    = 16'(e3);
        return v;
    endfunction

    function automatic logic [MAT_W-1:0] win_matrix(input int r, input int c);
        logic [MAT_W-1:0] m;
        m = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                m = {m[MAT_W-DATA_W-1:0], DATA_W'((r - 2 + dr) * W + (c - 2 + dc) + 1)};
            end
        end
        return m;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            if (done) n_done++;
            if (res_valid) begin
                n_res++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_res: got data %0d at (%0d,%0d) expected none",
                             res_data, res_row, res_col);
                end else begin
                    e = sbq.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_row", res_row, e.row);
                    check("res_col", res_col, e.col);
                end
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int   done_at;
        int   res0;
        int   done0;
        logic win;
        res_t e;
        res0  = n_res;
        done0 = n_done;
        coef_data = {9{v.coef}};
        coef_load = 1'b1;
        start     = 1'b1;
        step();
        coef_load = 1'b0;
        start     = 1'b0;
        check("busy_after_start", busy, 1);
        check("coef_captured", filt_coef, {9{v.coef}});
        for (int k = 0; k < W * H; k++) begin
            int r = k / W;
            int c = k % W;
            if (v.gap) begin
                pix_valid = 1'b0;
                if (v.mid_start) start = 1'b1;
                step();
                start = 1'b0;
                check("gap_no_ena", filt_ena, 0);
            end
            pix_valid = 1'b1;
            pix_data  = DATA_W'(k + 1);
            if (v.mid_coef && k == 5) begin
                coef_load = 1'b1;
                coef_data = {9{NUM_2}};
            end
            if (v.mid_start && k == 6) start = 1'b1;
            check("pix_ready", pix_ready, 1);
            win = (r >= 2) && (c >= 2) && (!STRIDE2 || ((r % 2) == 0 && (c % 2) == 0));
            if (win) begin
                e.data = v.res[(r - 2) * 2 + (c - 2)];
                e.row  = 8'(r - 2);
                e.col  = 8'(c - 2);
                sbq.push_back(e);
            end
            step();
            pix_valid = 1'b0;
            coef_load = 1'b0;
            start     = 1'b0;
            check("filt_ena", filt_ena, win);
            if (win) check("filt_matrix", filt_matrix, win_matrix(r, c));
        end
        done_at = 0;
        for (int i = 1; i <= FLAT + 4; i++) begin
            if (done && done_at == 0) done_at = i;
            step();
        end
        check("done_cycle", done_at, FLAT);
        check("done_count", n_done - done0, 1);
        check("busy_idle", busy, 0);
        check("res_count", n_res - res0, NWIN);
        check("sb_empty", sbq.size(), 0);
        check("coef_kept", filt_coef, {9{v.coef}});
    endtask

    initial begin
        int res0;
        int done0;
        n_cmp = 0;
        n_bad = 0;
        n_res = 0;
        n_done = 0;
        rst = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        coef_load = 1'b0;
        coef_data = '0;

        vecs[0] = mk(NUM_1, 1'b0, 1'b0, 1'b0, 54, 63, 90, 99);
        vecs[1] = mk(NUM_1, 1'b1, 1'b0, 1'b0, 54, 63, 90, 99);
        vecs[2] = mk(NUM_1, 1'b0, 1'b1, 1'b0, 54, 63, 90, 99);
        vecs[3] = mk(NUM_2, 1'b0, 1'b0, 1'b0, 108, 126, 180, 198);
        vecs[4] = mk(NUM_1, 1'b1, 1'b0, 1'b1, 54, 63, 90, 99);

        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_done", done, 0);
        check("rst_ena", filt_ena, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_coef", filt_coef, 0);
        check("rst_matrix", filt_matrix, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
        end

        // Abort a frame with reset just after pixel 10 is accepted.
        res0  = n_res;
        done0 = n_done;
        coef_data = {9{NUM_1}};
        coef_load = 1'b1;
        start     = 1'b1;
        step();
        coef_load = 1'b0;
        start     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pix_valid = 1'b1;
            pix_data  = DATA_W'(k + 1);
            step();
        end
        pix_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", pix_ready, 0);
        check("abort_done", done, 0);
        check("abort_ena", filt_ena, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_coef", filt_coef, 0);
        check("abort_matrix", filt_matrix, 0);
        check("abort_res_data", res_data, 0);
        check("abort_res_row", res_row, 0);
        check("abort_res_col", res_col, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("abort_no_done", n_done - done0, 0);
        check("abort_no_res", n_res - res0, 0);
        check("abort_idle", busy, 0);

        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end
endmodule
